// File: rtl/sync_fifo_param.sv
// sync_fifo_param
// ---------------
// Single-clock parametrised FIFO that buffers samples between the
// coefficient/sample loader and the FIR datapath.
//
// Parameters
//   DATAWIDTH  data word width
//   ADDRWIDTH  address width, DEPTH = 2**ADDRWIDTH
//   AFULL_TH   oAFULL asserts when level >= AFULL_TH
//   AEMPT_TH   oAEMPT asserts when level <= AEMPT_TH
//   FWFT       0 = registered read (data one cycle after the accepting edge)
//              1 = first-word-fall-through (head word shown combinationally)
//
// Ports
//   iCLK    clock, rising edge
//   iRSTN   asynchronous active-low reset
//   iCLR    synchronous flush, beats any simultaneous read/write request
//   iWDAT   write data          iWINC  write request
//   iRINC   read request        oRDAT  read data
//   oFULL / oAFULL / oEMPT / oAEMPT  occupancy flags decoded from the level
//   oLEVEL  occupancy 0..DEPTH
//   oOVF    sticky, write attempted while full
//   oUDF    sticky, read attempted while empty
module sync_fifo_param #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 4,
    parameter int AFULL_TH  = 14,
    parameter int AEMPT_TH  = 2,
    parameter int FWFT      = 0
) (
    input  logic                 iCLK,
    input  logic                 iRSTN,
    input  logic                 iCLR,
    input  logic [DATAWIDTH-1:0] iWDAT,
    input  logic                 iWINC,
    output logic                 oFULL,
    output logic                 oAFULL,
    input  logic                 iRINC,
    output logic [DATAWIDTH-1:0] oRDAT,
    output logic                 oEMPT,
    output logic                 oAEMPT,
    output logic [ADDRWIDTH:0]   oLEVEL,
    output logic                 oOVF,
    output logic                 oUDF
);

    localparam int DEPTH = 1 << ADDRWIDTH;

    // Thresholds sized to the level counter so the flag compares stay width-clean.
    localparam logic [ADDRWIDTH:0]   DEPTH_L = (ADDRWIDTH+1)'(DEPTH);
    localparam logic [ADDRWIDTH:0]   AFULL_L = (ADDRWIDTH+1)'(AFULL_TH);
    localparam logic [ADDRWIDTH:0]   AEMPT_L = (ADDRWIDTH+1)'(AEMPT_TH);
    localparam logic [ADDRWIDTH:0]   LVL_ONE = (ADDRWIDTH+1)'(1);
    localparam logic [ADDRWIDTH-1:0] PTR_ONE = ADDRWIDTH'(1);

    logic [DATAWIDTH-1:0] mem [DEPTH];

    logic [ADDRWIDTH-1:0] wptr_reg;
    logic [ADDRWIDTH-1:0] rptr_reg;
    logic [ADDRWIDTH:0]   level_reg;
    logic [ADDRWIDTH:0]   level_next;
    logic                 ovf_reg;
    logic                 udf_reg;

    logic                 full;
    logic                 empt;
    logic                 wr_acc;
    logic                 rd_acc;

    // Flags are pure decodes of the level register: they move on the same
    // edge as the level, with no extra pipeline stage.
    assign full   = (level_reg == DEPTH_L);
    assign empt   = (level_reg == '0);
    assign oFULL  = full;
    assign oEMPT  = empt;
    assign oAFULL = (level_reg >= AFULL_L);
    assign oAEMPT = (level_reg <= AEMPT_L);
    assign oLEVEL = level_reg;
    assign oOVF   = ovf_reg;
    assign oUDF   = udf_reg;

    // Accepts look only at the current flags, so when full a simultaneous
    // read does not make room for the write in that cycle (and vice versa
    // when empty: no write-to-read bypass).
    assign wr_acc = iWINC & ~full;
    assign rd_acc = iRINC & ~empt;

    always_comb begin
        level_next = level_reg;
        if (wr_acc && !rd_acc) begin
            level_next = level_reg + LVL_ONE;
        end else if (rd_acc && !wr_acc) begin
            level_next = level_reg - LVL_ONE;
        end
    end

    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            level_reg <= '0;
            ovf_reg   <= 1'b0;
            udf_reg   <= 1'b0;
        end else if (iCLR) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            level_reg <= '0;
            ovf_reg   <= 1'b0;
            udf_reg   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr_reg <= wptr_reg + PTR_ONE;
            end
            if (rd_acc) begin
                rptr_reg <= rptr_reg + PTR_ONE;
            end
            level_reg <= level_next;
            if (iWINC && full) begin
                ovf_reg <= 1'b1;
            end
            if (iRINC && empt) begin
                udf_reg <= 1'b1;
            end
        end
    end

    // Storage has no reset; a flush discards the pending write as well.
    always_ff @(posedge iCLK) begin
        if (wr_acc && !iCLR) begin
            mem[wptr_reg] <= iWDAT;
        end
    end

    generate
        if (FWFT == 0) begin : g_std_read
            logic [DATAWIDTH-1:0] rdat_reg;

            always_ff @(posedge iCLK or negedge iRSTN) begin
                if (!iRSTN) begin
                    rdat_reg <= '0;
                end else if (iCLR) begin
                    rdat_reg <= '0;
                end else if (rd_acc) begin
                    rdat_reg <= mem[rptr_reg];
                end
            end

            assign oRDAT = rdat_reg;
        end else begin : g_fwft_read
            // Head of queue is always on the output; meaningless while empty.
            assign oRDAT = mem[rptr_reg];
        end
    endgenerate

endmodule
